// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and serial line bundle for uart_tx
interface uart_tx_if;
   logic       i_tx_valid;
   logic [7:0] i_tx_data;
   logic       o_tx_ready;
   logic       o_txd;
   logic       o_tx_busy;
   logic       o_tx_done;

   modport master (
      output i_tx_valid,
      output i_tx_data,
      input  o_tx_ready,
      input  o_txd,
      input  o_tx_busy,
      input  o_tx_done
   );

   modport slave (
      input  i_tx_valid,
      input  i_tx_data,
      output o_tx_ready,
      output o_txd,
      output o_tx_busy,
      output o_tx_done
   );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with byte FIFO and back-to-back framing
module uart_tx #(
   parameter int CLKS_PER_BIT = 391,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic     i_clk,
   input  logic     i_rst,
   uart_tx_if.slave tx
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [PTR_W:0]   FULL     = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             txd, txd_nxt;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count, count_nxt;
   logic [7:0]       rd_data;
   logic             ready, push, pop, cnt_last, fifo_nempty;

   assign ready       = ~i_rst & (count != FULL);
   assign push        = tx.i_tx_valid & ready;
   assign fifo_nempty = (count != '0);
   assign rd_data     = mem[rd_ptr];
   assign cnt_last    = (cnt == CNT_LAST);

   assign tx.o_tx_ready = ready;
   assign tx.o_txd      = txd;
   assign tx.o_tx_busy  = (state != S_IDLE) | fifo_nempty;
   assign tx.o_tx_done  = (state == S_STOP) & cnt_last;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         idx    <= '0;
         shift  <= '0;
         txd    <= 1'b1;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         shift  <= shift_nxt;
         txd    <= txd_nxt;
         count  <= count_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Storage needs no reset: count alone decides which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= tx.i_tx_data;
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + (PTR_W + 1)'(1);
         2'b01:   count_nxt = count - (PTR_W + 1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shift_nxt = shift;
      txd_nxt   = txd;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            txd_nxt = 1'b1;
            if (fifo_nempty) begin
               pop       = 1'b1;
               shift_nxt = rd_data;
               cnt_nxt   = '0;
               txd_nxt   = 1'b0;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (cnt_last) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               txd_nxt   = shift[0];
               state_nxt = S_DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_last) begin
               cnt_nxt   = '0;
               shift_nxt = {1'b0, shift[7:1]};
               idx_nxt   = idx + 3'd1;
               if (idx == 3'd7) begin
                  txd_nxt   = 1'b1;
                  state_nxt = S_STOP;
               end else begin
                  txd_nxt = shift[1];
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_last) begin
               cnt_nxt = '0;
               // Chain straight into the next start bit so queued frames have no gap.
               if (fifo_nempty) begin
                  pop       = 1'b1;
                  shift_nxt = rd_data;
                  txd_nxt   = 1'b0;
                  state_nxt = S_START;
               end else begin
                  txd_nxt   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            txd_nxt   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   dcnt [3];

   always #5 clk = ~clk;

   uart_tx_if if16 ();
   uart_tx_if if8 ();
   uart_tx_if if391 ();

   uart_tx #(.CLKS_PER_BIT(16),  .FIFO_DEPTH(4)) dut16  (.i_clk(clk), .i_rst(rst), .tx(if16));
   uart_tx #(.CLKS_PER_BIT(8),   .FIFO_DEPTH(4)) dut8   (.i_clk(clk), .i_rst(rst), .tx(if8));
   uart_tx #(.CLKS_PER_BIT(391), .FIFO_DEPTH(4)) dut391 (.i_clk(clk), .i_rst(rst), .tx(if391));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (if16.o_tx_done  === 1'b1) dcnt[0] <= dcnt[0] + 1;
      if (if8.o_tx_done   === 1'b1) dcnt[1] <= dcnt[1] + 1;
      if (if391.o_tx_done === 1'b1) dcnt[2] <= dcnt[2] + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic v, input logic [7:0] d);
      case (sel)
         0:       begin if16.i_tx_valid  = v; if16.i_tx_data  = d; end
         1:       begin if8.i_tx_valid   = v; if8.i_tx_data   = d; end
         default: begin if391.i_tx_valid = v; if391.i_tx_data = d; end
      endcase
   endtask

   function automatic logic f_txd(input int sel);
      case (sel)
         0:       return if16.o_txd;
         1:       return if8.o_txd;
         default: return if391.o_txd;
      endcase
   endfunction

   function automatic logic f_done(input int sel);
      case (sel)
         0:       return if16.o_tx_done;
         1:       return if8.o_tx_done;
         default: return if391.o_tx_done;
      endcase
   endfunction

   function automatic logic f_busy(input int sel);
      case (sel)
         0:       return if16.o_tx_busy;
         1:       return if8.o_tx_busy;
         default: return if391.o_tx_busy;
      endcase
   endfunction

   function automatic logic f_ready(input int sel);
      case (sel)
         0:       return if16.o_tx_ready;
         1:       return if8.o_tx_ready;
         default: return if391.o_tx_ready;
      endcase
   endfunction

   // Returns at the sample just after the accepting edge, valid dropped.
   task automatic push(input int sel, input logic [7:0] d);
      int n;
      n = 0;
      drive(sel, 1'b1, d);
      while (f_ready(sel) !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (f_ready(sel) !== 1'b1) begin
         failures++;
         $display("FAIL push_timeout: dut %0d ready=%b after %0d cycles, required 1", sel, f_ready(sel), n);
      end
      tick();
      drive(sel, 1'b0, d);
   endtask

   task automatic wait_fall(input int sel, input int bound, input string name);
      int n;
      n = 0;
      while (f_txd(sel) !== 1'b0 && n < bound) begin
         tick();
         n++;
      end
      checks++;
      if (f_txd(sel) !== 1'b0) begin
         failures++;
         $display("FAIL %s_fall: txd=%b after %0d cycles, required 0", name, f_txd(sel), n);
      end
   endtask

   // Starts at the first start-bit sample, ends at the last stop-bit sample.
   task automatic check_frame(input int sel, input int cpb, input logic [7:0] exp, input string name);
      logic eb;
      int   bad;
      int   dh;
      int   dlast;
      dh = 0;
      dlast = 0;
      for (int b = 0; b < 10; b++) begin
         if (b == 0)      eb = 1'b0;
         else if (b == 9) eb = 1'b1;
         else             eb = exp[b-1];
         bad = 0;
         for (int i = 0; i < cpb; i++) begin
            if (f_txd(sel) !== eb) bad++;
            if (f_done(sel) === 1'b1) begin
               dh++;
               if (b == 9 && i == cpb - 1) dlast = 1;
            end
            if (!(b == 9 && i == cpb - 1)) tick();
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL %s_bit%0d: %0d of %0d cycles differ, required level %b", name, b, bad, cpb, eb);
         end
      end
      checks++;
      if (dh != 1 || dlast != 1) begin
         failures++;
         $display("FAIL %s_done: pulses=%0d in_last_cycle=%0d, required 1 and 1", name, dh, dlast);
      end
   endtask

   task automatic test_reset;
      tick();
      tick();
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (f_ready(s) !== 1'b0) begin failures++; $display("FAIL reset_ready%0d: got %b, required 0", s, f_ready(s)); end
         checks++;
         if (f_txd(s) !== 1'b1) begin failures++; $display("FAIL reset_txd%0d: got %b, required 1", s, f_txd(s)); end
         checks++;
         if (f_busy(s) !== 1'b0) begin failures++; $display("FAIL reset_busy%0d: got %b, required 0", s, f_busy(s)); end
         checks++;
         if (f_done(s) !== 1'b0) begin failures++; $display("FAIL reset_done%0d: got %b, required 0", s, f_done(s)); end
      end
      rst = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (f_ready(s) !== 1'b1) begin failures++; $display("FAIL release_ready%0d: got %b, required 1", s, f_ready(s)); end
      end
   endtask

   task automatic test_single;
      int d0;
      d0 = dcnt[0];
      drive(0, 1'b1, 8'hA5);
      tick();
      drive(0, 1'b0, 8'h00);
      checks++;
      if (if16.o_tx_busy !== 1'b1) begin failures++; $display("FAIL single_busy_at_accept: got %b, required 1", if16.o_tx_busy); end
      checks++;
      if (if16.o_txd !== 1'b1) begin failures++; $display("FAIL single_txd_at_accept: got %b, required 1", if16.o_txd); end
      tick();
      checks++;
      if (if16.o_txd !== 1'b0) begin failures++; $display("FAIL single_latency: txd=%b one edge after accept, required 0", if16.o_txd); end
      check_frame(0, 16, 8'hA5, "single");
      tick();
      checks++;
      if (if16.o_tx_busy !== 1'b0) begin failures++; $display("FAIL single_busy_after: got %b, required 0", if16.o_tx_busy); end
      checks++;
      if (if16.o_txd !== 1'b1) begin failures++; $display("FAIL single_idle_txd: got %b, required 1", if16.o_txd); end
      checks++;
      if (dcnt[0] - d0 != 1) begin failures++; $display("FAIL single_done_count: got %0d, required 1", dcnt[0] - d0); end
   endtask

   task automatic test_held_data;
      push(0, 8'h5A);
      drive(0, 1'b0, 8'hFF);
      tick();
      drive(0, 1'b0, 8'h00);
      wait_fall(0, 5, "held");
      check_frame(0, 16, 8'h5A, "held");
      tick();
   endtask

   task automatic test_burst;
      logic [7:0] bb [6];
      int         acc [6];
      int         exp_acc [6];
      int         base;
      bb      = '{8'h11, 8'h2E, 8'hC3, 8'h74, 8'h9B, 8'h06};
      exp_acc = '{1, 2, 3, 4, 5, 83};
      base    = cyc;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               push(1, bb[i]);
               acc[i] = cyc - base;
               if (i == 4) begin
                  checks++;
                  if (if8.o_tx_ready !== 1'b0) begin failures++; $display("FAIL burst_full_ready: got %b, required 0", if8.o_tx_ready); end
               end
            end
         end
         begin
            wait_fall(1, 50, "burst");
            checks++;
            if (cyc - base != 2) begin failures++; $display("FAIL burst_fall_cycle: got %0d, required 2", cyc - base); end
            for (int f = 0; f < 6; f++) begin
               check_frame(1, 8, bb[f], $sformatf("burst%0d", f));
               tick();
            end
         end
      join
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (acc[i] != exp_acc[i]) begin failures++; $display("FAIL burst_accept%0d: edge %0d, required %0d", i, acc[i], exp_acc[i]); end
      end
      checks++;
      if (if8.o_tx_busy !== 1'b0) begin failures++; $display("FAIL burst_busy_after: got %b, required 0", if8.o_tx_busy); end
   endtask

   task automatic test_simul_push_pop;
      logic [7:0] bb [5];
      bb = '{8'hE1, 8'h3D, 8'h80, 8'h01, 8'hB6};
      fork
         begin
            int n;
            for (int i = 0; i < 4; i++) push(1, bb[i]);
            n = 0;
            while (if8.o_tx_done !== 1'b1 && n < 200) begin
               tick();
               n++;
            end
            checks++;
            if (if8.o_tx_done !== 1'b1) begin failures++; $display("FAIL simul_done_wait: done=%b after %0d cycles, required 1", if8.o_tx_done, n); end
            checks++;
            if (if8.o_tx_ready !== 1'b1) begin failures++; $display("FAIL simul_ready_before: got %b, required 1", if8.o_tx_ready); end
            drive(1, 1'b1, bb[4]);
            tick();
            drive(1, 1'b0, 8'h00);
            checks++;
            if (if8.o_tx_ready !== 1'b1) begin failures++; $display("FAIL simul_ready_after: got %b, required 1", if8.o_tx_ready); end
         end
         begin
            wait_fall(1, 50, "simul");
            for (int f = 0; f < 5; f++) begin
               check_frame(1, 8, bb[f], $sformatf("simul%0d", f));
               tick();
            end
         end
      join
   endtask

   task automatic test_reset_mid;
      int base;
      int d0;
      int lows;
      base = cyc;
      push(0, 8'hF7);
      push(0, 8'h42);
      push(0, 8'h99);
      while (cyc < base + 72) tick();
      checks++;
      if (if16.o_txd !== 1'b0) begin failures++; $display("FAIL rstmid_bit3: got %b, required 0", if16.o_txd); end
      d0 = dcnt[0];
      rst = 1'b1;
      tick();
      checks++;
      if (if16.o_txd !== 1'b1) begin failures++; $display("FAIL rstmid_txd: got %b, required 1", if16.o_txd); end
      checks++;
      if (if16.o_tx_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b, required 0", if16.o_tx_busy); end
      checks++;
      if (if16.o_tx_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready_in_reset: got %b, required 0", if16.o_tx_ready); end
      rst = 1'b0;
      lows = 0;
      repeat (300) begin
         tick();
         if (if16.o_txd !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin failures++; $display("FAIL rstmid_quiet: %0d non-idle cycles, required 0", lows); end
      checks++;
      if (dcnt[0] - d0 != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d pulses, required 0", dcnt[0] - d0); end
      push(0, 8'h3C);
      wait_fall(0, 5, "rstmid");
      check_frame(0, 16, 8'h3C, "rstmid_after");
      tick();
   endtask

   task automatic test_loopback;
      logic [7:0] bb [4];
      int         d0;
      bb = '{8'h00, 8'hFF, 8'h55, 8'h80};
      d0 = dcnt[2];
      fork
         begin
            for (int i = 0; i < 4; i++) push(2, bb[i]);
         end
         begin
            logic [7:0] r;
            for (int f = 0; f < 4; f++) begin
               wait_fall(2, 5000, "loop");
               repeat (195) tick();
               checks++;
               if (if391.o_txd !== 1'b0) begin failures++; $display("FAIL loop%0d_start: got %b, required 0", f, if391.o_txd); end
               for (int j = 0; j < 8; j++) begin
                  repeat (391) tick();
                  r[j] = if391.o_txd;
               end
               repeat (391) tick();
               checks++;
               if (if391.o_txd !== 1'b1) begin failures++; $display("FAIL loop%0d_stop: got %b, required 1", f, if391.o_txd); end
               checks++;
               if (r !== bb[f]) begin failures++; $display("FAIL loop%0d_byte: got %h, required %h", f, r, bb[f]); end
               repeat (195) tick();
               checks++;
               if (if391.o_tx_done !== 1'b1) begin failures++; $display("FAIL loop%0d_done: got %b, required 1", f, if391.o_tx_done); end
               tick();
            end
         end
      join
      checks++;
      if (dcnt[2] - d0 != 4) begin failures++; $display("FAIL loop_done_count: got %0d, required 4", dcnt[2] - d0); end
   endtask

   initial begin
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      drive(2, 1'b0, 8'h00);
      test_reset();
      test_single();
      test_held_data();
      test_burst();
      test_simul_push_pop();
      test_reset_mid();
      test_loopback();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
